// File: rtl/sub_serial_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// Port m exists only when SUB_SERIAL_MOD_CORRECT_EN is defined.
`timescale 1ns/1ps
interface sub_serial_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SUB_SERIAL_MOD_CORRECT_EN
    logic [WIDTH-1:0] m;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    modport master (
`ifdef SUB_SERIAL_MOD_CORRECT_EN
        output m,
`endif
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow
    );

    modport slave (
`ifdef SUB_SERIAL_MOD_CORRECT_EN
        input  m,
`endif
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow
    );
endinterface

// File: rtl/sub_serial.sv
// Bit-serial unsigned subtractor, one bit per cycle LSB first, with valid/ready on both sides.
// Define SUB_SERIAL_MOD_CORRECT_EN to add a serial "+m" correction pass when a < b.
`timescale 1ns/1ps
module sub_serial #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    sub_serial_if.slave    bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SUB, CORR, DONE} state_t;

    state_t           state_r, state_nxt;
    logic [CW-1:0]    cnt_r;
    logic             br_r, br_nxt;
    logic [WIDTH-1:0] res_r, res_nxt;
    logic [WIDTH-1:0] diff_r;
    logic             borrow_r;
    logic [WIDTH-1:0] a_r, b_r;
`ifdef SUB_SERIAL_MOD_CORRECT_EN
    logic [WIDTH-1:0] m_r;
`endif
    logic             last;

    // Full-subtractor bit: returns {borrow_out, diff_bit}.
    function automatic logic [1:0] sub_bit(input logic ai, input logic bi, input logic bri);
        sub_bit = {(~ai & bi) | (~(ai ^ bi) & bri), ai ^ bi ^ bri};
    endfunction

    // Full-adder bit: returns {carry_out, sum_bit}.
    function automatic logic [1:0] add_bit(input logic xi, input logic yi, input logic ci);
        add_bit = {(xi & yi) | (ci & (xi ^ yi)), xi ^ yi ^ ci};
    endfunction

    always_comb begin
        state_nxt = state_r;
        res_nxt   = res_r;
        br_nxt    = br_r;
        last      = (cnt_r == LAST);
        case (state_r)
            IDLE: if (bus.in_valid) state_nxt = SUB;
            SUB: begin
                {br_nxt, res_nxt[cnt_r]} = sub_bit(a_r[cnt_r], b_r[cnt_r], br_r);
                if (last) begin
`ifdef SUB_SERIAL_MOD_CORRECT_EN
                    state_nxt = br_nxt ? CORR : DONE;
`else
                    state_nxt = DONE;
`endif
                end
            end
            CORR: begin
`ifdef SUB_SERIAL_MOD_CORRECT_EN
                {br_nxt, res_nxt[cnt_r]} = add_bit(res_r[cnt_r], m_r[cnt_r], br_r);
                if (last) state_nxt = DONE;
`else
                state_nxt = IDLE;
`endif
            end
            DONE: if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            cnt_r    <= '0;
            br_r     <= 1'b0;
            res_r    <= '0;
            diff_r   <= '0;
            borrow_r <= 1'b0;
        end else begin
            state_r <= state_nxt;
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        cnt_r <= '0;
                        br_r  <= 1'b0;
                    end
                end
                SUB, CORR: begin
                    res_r <= res_nxt;
                    if (last) begin
                        // br_r doubles as the carry of the correction pass, so it restarts at 0.
                        cnt_r <= '0;
                        br_r  <= 1'b0;
                        if (state_nxt == DONE) begin
                            diff_r   <= res_nxt;
                            borrow_r <= (state_r == CORR) | br_nxt;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                        br_r  <= br_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    // Operand registers only load on acceptance and need no reset.
    always_ff @(posedge clk) begin
        if (state_r == IDLE && bus.in_valid) begin
            a_r <= bus.a;
            b_r <= bus.b;
`ifdef SUB_SERIAL_MOD_CORRECT_EN
            m_r <= bus.m;
`endif
        end
    end

    assign bus.in_ready  = (state_r == IDLE);
    assign bus.out_valid = (state_r == DONE);
    assign bus.diff      = diff_r;
    assign bus.borrow    = borrow_r;
endmodule
